// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding and defaults for the watchdog escalation controller.
package wdt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, RSTOUT = 2'd2} wdt_esc_state_e;
  localparam int WDT_GRACE_DEFAULT = 1024;
  localparam int WDT_RST_PULSE_DEFAULT = 16;
  localparam int WDT_STAT_W = 8;
endpackage

// File: rtl/wdt_escalation_ctrl_if.sv
// wdt_escalation_ctrl_if: timeout input, acknowledge and status outputs of the escalation controller.
interface wdt_escalation_ctrl_if;
  import wdt_pkg::*;
  logic wto;
  logic irq_clr;
  logic irq;
  logic sys_rst_req;
  logic busy;
  logic [WDT_STAT_W-1:0] timeout_cnt;
  logic [WDT_STAT_W-1:0] rst_cnt;
  modport master (output wto, irq_clr, input irq, sys_rst_req, busy, timeout_cnt, rst_cnt);
  modport slave (input wto, irq_clr, output irq, sys_rst_req, busy, timeout_cnt, rst_cnt);
endinterface

// File: rtl/wdt_escalation_ctrl.sv
// wdt_escalation_ctrl: watchdog timeout -> irq -> reset-request escalation.
// Escalation (grace/pulse counters, RSTOUT) is compiled only with WDT_ESCALATION_EN.
module wdt_escalation_ctrl
  import wdt_pkg::*;
#(
  parameter int GRACE_CYCLES = WDT_GRACE_DEFAULT,
  parameter int RST_PULSE_CYCLES = WDT_RST_PULSE_DEFAULT
) (
  input logic clk,
  input logic rst,
  wdt_escalation_ctrl_if.slave bus
);
  wdt_esc_state_e state, state_n;
  logic wto_q;
  logic wto_rise;
  logic [WDT_STAT_W-1:0] timeout_cnt;
  if (GRACE_CYCLES < 1 || RST_PULSE_CYCLES < 1) begin : g_bad_cfg
    $error("GRACE_CYCLES and RST_PULSE_CYCLES must be >= 1");
  end
  assign wto_rise = bus.wto & ~wto_q;
  assign bus.irq = state != IDLE;
  assign bus.busy = state != IDLE;
  assign bus.timeout_cnt = timeout_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wto_q <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      state <= state_n;
      wto_q <= bus.wto;
      timeout_cnt <= (wto_rise && timeout_cnt != '1) ? timeout_cnt + 1'b1 : timeout_cnt;
    end
`ifdef WDT_ESCALATION_EN
  localparam int GW = $clog2(GRACE_CYCLES + 1);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  logic [GW-1:0] grace_cnt;
  logic [PW-1:0] pulse_cnt;
  logic [WDT_STAT_W-1:0] rst_cnt;
  logic grace_done, pulse_done;
  assign grace_done = grace_cnt == GW'(GRACE_CYCLES - 1);
  assign pulse_done = pulse_cnt == PW'(RST_PULSE_CYCLES - 1);
  assign bus.sys_rst_req = state == RSTOUT;
  assign bus.rst_cnt = rst_cnt;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (wto_rise ? PEND : IDLE) :
              state == PEND ? (bus.irq_clr ? IDLE : grace_done ? RSTOUT : PEND) :
              (pulse_done ? IDLE : RSTOUT);
  end
  // Counters clear outside their state so each entry starts from zero; they stop advancing on exit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      grace_cnt <= '0;
      pulse_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      grace_cnt <= state == PEND ? grace_cnt + 1'b1 : '0;
      pulse_cnt <= state == RSTOUT ? pulse_cnt + 1'b1 : '0;
      rst_cnt <= (state == PEND && state_n == RSTOUT && rst_cnt != '1) ? rst_cnt + 1'b1 : rst_cnt;
    end
`else
  assign bus.sys_rst_req = 1'b0;
  assign bus.rst_cnt = '0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (wto_rise ? PEND : IDLE) :
              state == PEND ? (bus.irq_clr ? IDLE : PEND) : IDLE;
  end
`endif
endmodule

// File: tb/tb_wdt_escalation_ctrl.sv
// tb_wdt_escalation_ctrl: directed vector table plus hand sequences for escalation corner cases.
module tb_wdt_escalation_ctrl;
  import wdt_pkg::*;
  localparam int G = 8;
  localparam int P = 4;
`ifdef WDT_ESCALATION_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  wdt_escalation_ctrl_if bus();
  wdt_escalation_ctrl #(.GRACE_CYCLES(G), .RST_PULSE_CYCLES(P)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic wto;
    logic clr;
    logic irq;
    int tcnt;
  } vec_t;
  vec_t tbl[13];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    bus.wto = 1'b0;
    bus.irq_clr = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask
  task automatic run_esc(input int mode);
    do_reset();
    bus.wto = 1'b1;
    step();
    chk($sformatf("esc%0d irq at k", mode), bus.irq, 1);
    for (int c = 1; c <= 60; c++) begin
      bus.wto = mode == 1 ? (c < 50) : mode == 2 ? (c == 2 || c == 4 || c == 6) : 1'b0;
      step();
      chk($sformatf("esc%0d irq c%0d", mode, c), bus.irq, EN ? int'(c < G + P) : 1);
      chk($sformatf("esc%0d srr c%0d", mode, c), bus.sys_rst_req, int'(EN && c >= G && c < G + P));
    end
    chk($sformatf("esc%0d timeout_cnt", mode), bus.timeout_cnt, mode == 2 ? 4 : 1);
    chk($sformatf("esc%0d rst_cnt", mode), bus.rst_cnt, int'(EN));
    bus.wto = 1'b0;
    bus.irq_clr = 1'b1;
    step();
    bus.irq_clr = 1'b0;
    chk($sformatf("esc%0d irq after ack", mode), bus.irq, 0);
  endtask
  initial begin
    int bad;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 3};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 4};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 4};
    do_reset();
    chk("reset irq", bus.irq, 0);
    chk("reset srr", bus.sys_rst_req, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset timeout_cnt", bus.timeout_cnt, 0);
    chk("reset rst_cnt", bus.rst_cnt, 0);
    bad = 0;
    repeat (100) begin
      step();
      if (bus.irq || bus.sys_rst_req || bus.busy || bus.timeout_cnt != 0 || bus.rst_cnt != 0) bad++;
    end
    chk("idle100 nonzero cycles", bad, 0);
    for (int i = 0; i < 13; i++) begin
      bus.wto = tbl[i].wto;
      bus.irq_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d irq", i), bus.irq, tbl[i].irq);
      chk($sformatf("vec%0d busy", i), bus.busy, tbl[i].irq);
      chk($sformatf("vec%0d srr", i), bus.sys_rst_req, 0);
      chk($sformatf("vec%0d timeout_cnt", i), bus.timeout_cnt, tbl[i].tcnt);
      chk($sformatf("vec%0d rst_cnt", i), bus.rst_cnt, 0);
    end
    for (int m = 0; m < 3; m++) run_esc(m);
    do_reset();
    bus.wto = 1'b1;
    step();
    bus.wto = 1'b0;
    for (int c = 1; c < G; c++) step();
    chk("expiry irq before ack", bus.irq, 1);
    bus.irq_clr = 1'b1;
    step();
    bus.irq_clr = 1'b0;
    chk("expiry ack irq", bus.irq, 0);
    chk("expiry ack busy", bus.busy, 0);
    chk("expiry ack srr", bus.sys_rst_req, 0);
    bad = 0;
    repeat (10) begin
      step();
      if (bus.sys_rst_req || bus.irq) bad++;
    end
    chk("expiry ack quiet cycles", bad, 0);
    chk("expiry ack rst_cnt", bus.rst_cnt, 0);
    do_reset();
    bus.wto = 1'b1;
    step();
    bus.wto = 1'b0;
    repeat (G + 1) step();
    chk("mid srr before rst", bus.sys_rst_req, int'(EN));
    chk("mid timeout_cnt before rst", bus.timeout_cnt, 1);
    rst = 1'b0;
    #1;
    chk("async rst irq", bus.irq, 0);
    chk("async rst srr", bus.sys_rst_req, 0);
    chk("async rst busy", bus.busy, 0);
    chk("async rst timeout_cnt", bus.timeout_cnt, 0);
    chk("async rst rst_cnt", bus.rst_cnt, 0);
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      bus.wto = 1'b1;
      step();
      if (i == 254) chk("timeout_cnt at 255 rises", bus.timeout_cnt, 255);
      bus.wto = 1'b0;
      step();
    end
    chk("timeout_cnt saturated", bus.timeout_cnt, 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wdt_escalation_ctrl.md
# wdt_escalation_ctrl

Single-clock block directly downstream of the watchdog wrapper. It consumes the watchdog timeout level `wto` and turns each timeout into a CPU interrupt. If software does not acknowledge that interrupt within a grace window, it escalates to a fixed-width system-reset request pulse. It also keeps saturating counts of timeouts and escalations for debug and status readout.

## Interface
Parameters:
- `GRACE_CYCLES`, default 1024: clk cycles between interrupt assertion and reset escalation; legal range ≥ 1.
- `RST_PULSE_CYCLES`, default 16: width of the `sys_rst_req` pulse in clk cycles; legal range ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `wto`, in, 1: watchdog timeout level from the watchdog wrapper, already synchronous to `clk`.
- `irq_clr`, in, 1: single-cycle software acknowledge.
- `irq`, out, 1: watchdog interrupt to the CPU, level.
- `sys_rst_req`, out, 1: active-high system-reset request pulse.
- `timeout_cnt`, out, 8: saturating count of `wto` rising edges.
- `rst_cnt`, out, 8: saturating count of issued reset pulses.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Edge detect: `wto_q` is a register holding last cycle's `wto`; `wto_rise = wto & ~wto_q`. A level that stays high never retriggers.
- Reset values: all outputs 0, `wto_q` 0, state IDLE, grace and pulse counters 0.
- States are IDLE, PEND and RSTOUT.
- **IDLE**
  - On `wto_rise`: go to PEND, set `irq` to 1, clear the grace counter.
  - `irq_clr` has no effect.
- **PEND** (`irq` is 1)
  - On `irq_clr`: go to IDLE, set `irq` to 0.
  - Otherwise, when the grace counter equals `GRACE_CYCLES-1`: go to RSTOUT, set `sys_rst_req` to 1, clear the pulse counter.
  - Otherwise: increment the grace counter.
  - If `irq_clr` and grace expiry happen in the same cycle, `irq_clr` wins and no escalation occurs.
- **RSTOUT** (`irq` is 1, `sys_rst_req` is 1)
  - `irq_clr` is ignored.
  - When the pulse counter equals `RST_PULSE_CYCLES-1`: go to IDLE, set `sys_rst_req` to 0 and `irq` to 0.
  - Otherwise: increment the pulse counter.
- `timeout_cnt`:
  - Increments on every `wto_rise` in every state, saturating at 255.
  - A `wto_rise` in PEND or RSTOUT does not restart the grace or pulse counter.
- `rst_cnt`: increments on the PEND→RSTOUT transition, saturating at 255.
- Counter widths:
  - Grace counter: `$clog2(GRACE_CYCLES+1)` bits.
  - Pulse counter: `$clog2(RST_PULSE_CYCLES+1)` bits.
  - Neither counter wraps inside its state.
- The block is not reset by its own `sys_rst_req`. It lives in the always-on `rst` domain.
- `rst` asserted mid-operation returns everything to the reset values immediately (asynchronous). No pulse is stretched across reset.

## Timing
- `wto` sampled 1 at edge k with `wto_q` = 0: `irq` is 1 and state is PEND after edge k.
- Without acknowledge:
  - `sys_rst_req` rises after edge k+`GRACE_CYCLES`.
  - `sys_rst_req` falls after edge k+`GRACE_CYCLES`+`RST_PULSE_CYCLES`.
  - `irq` falls on the same edge as `sys_rst_req`.
- `irq_clr` sampled at edge m while in PEND: `irq` is 0 after edge m.
- A new `wto_rise` at the same edge as the return to IDLE is not taken. IDLE acts on it one edge later, provided `wto` has fallen and risen again.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `WDT_ESCALATION_EN`.
- Defined:
  - Full behaviour as described above.
- Undefined:
  - The grace counter, pulse counter and RSTOUT state are not compiled.
  - PEND is left only via `irq_clr`.
  - `sys_rst_req` and `rst_cnt` are tied to 0.
  - `timeout_cnt`, `irq` and `busy` behave as described above.

## Structure
- Shared package `wdt_pkg` holds:
  - The state enum typedef `wdt_esc_state_e` (IDLE=2'd0, PEND=2'd1, RSTOUT=2'd2).
  - The default constants `WDT_GRACE_DEFAULT` and `WDT_RST_PULSE_DEFAULT`.
  - The status counter width `WDT_STAT_W = 8`.
- No sub-module: the edge detect, the two counters and the FSM are written inline.

## Test plan
- Reset, then `wto` held low for 100 cycles -> all outputs 0 and `busy` 0.
- `GRACE_CYCLES`=8, one `wto` rise, `irq_clr` 3 cycles later -> `irq` high for exactly 4 cycles, `sys_rst_req` never asserts, `timeout_cnt`=1, `rst_cnt`=0.
- `GRACE_CYCLES`=8, `RST_PULSE_CYCLES`=4, no acknowledge -> `sys_rst_req` high from edge k+8 for 4 cycles, `irq` drops with it, `rst_cnt`=1.
- `irq_clr` on the expiry cycle (PEND, grace counter = 7) -> return to IDLE, no reset pulse.
- `wto` held high for 50 cycles, plus three extra `wto` rises during PEND -> single interrupt, grace timing unchanged, `timeout_cnt`=4.
- `rst` asserted midway through RSTOUT -> `sys_rst_req` and `irq` go to 0 immediately; 300 timeouts drive `timeout_cnt` to saturate at 255.
